// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
// The legal offset/byte-enable table is only consulted when DM_MISALIGN_TRAP_EN is defined.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dm_state_e;

    // Legal byte-enable patterns per addr[1:0]; short rows repeat an entry as padding.
    localparam logic [3:0] LEGAL_BE [4][3] = '{
        '{4'b1111, 4'b0011, 4'b0001},
        '{4'b0010, 4'b0010, 4'b0010},
        '{4'b1100, 4'b0100, 4'b0100},
        '{4'b1000, 4'b1000, 4'b1000}
    };

    function automatic logic is_aligned(input logic [1:0] lo, input logic [3:0] be);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (be == LEGAL_BE[lo][k]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Single-port word RAM built from four byte-lane arrays, write-first:
// an enabled access returns the post-write word on the same edge.
module dm_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && be[gi]) begin
                        mem[idx]    <= wdata[8*gi +: 8];
                        rd_lane_reg <= wdata[8*gi +: 8];
                    end else begin
                        rd_lane_reg <= mem[idx];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency load/store responder with stall generation and a byte-writable RAM.
// Define DM_MISALIGN_TRAP_EN to add the err port and trap illegal offset/byte-enable pairs.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
`ifdef DM_MISALIGN_TRAP_EN
    output logic        err,
`endif
    output logic        stall
);

    localparam int AW     = clog2(DEPTH_WORDS);
    localparam int CW     = clog2(LATENCY + 1);
    localparam bit DIRECT = (LATENCY == 1);

    dm_state_e     state_reg;
    logic [CW-1:0] count_reg;
    logic          we_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          mask_reg;

    logic          access;
    logic          acc_we;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_ok;
    logic [31:0]   ram_rdata;

    // With LATENCY==1 the RAM is accessed on the accept edge, so it sees the live request.
    assign acc_we    = DIRECT ? req_we            : we_reg;
    assign acc_idx   = DIRECT ? req_addr[AW+1:2]  : idx_reg;
    assign acc_wdata = DIRECT ? req_wdata         : wdata_reg;
    assign acc_be    = DIRECT ? req_be            : be_reg;

`ifdef DM_MISALIGN_TRAP_EN
    logic [1:0] lo_reg;
    logic [1:0] acc_lo;
    logic       unused_addr;
    assign acc_lo      = DIRECT ? req_addr[1:0] : lo_reg;
    assign acc_ok      = is_aligned(acc_lo, acc_be);
    assign unused_addr = ^req_addr[31:AW+2];
`else
    logic       unused_addr;
    assign acc_ok      = 1'b1;
    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // The edge that enters DONE; reset gates it so a pending store is dropped.
    assign access = reset && enable &&
                    (((state_reg == IDLE) && req_valid && DIRECT) ||
                     ((state_reg == BUSY) && (count_reg == CW'(1))));

    assign req_ready  = (state_reg == IDLE) && enable;
    assign stall      = ((state_reg == IDLE) && req_valid) || (state_reg == BUSY);
    assign resp_rdata = mask_reg ? 32'd0 : ram_rdata;

    dm_byte_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (access),
        .we    (acc_we & acc_ok),
        .be    (acc_be),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            resp_valid <= 1'b0;
            mask_reg   <= 1'b1;
            we_reg     <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= '0;
            be_reg     <= '0;
`ifdef DM_MISALIGN_TRAP_EN
            lo_reg     <= '0;
            err        <= 1'b0;
`endif
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        idx_reg   <= req_addr[AW+1:2];
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
`ifdef DM_MISALIGN_TRAP_EN
                        lo_reg    <= req_addr[1:0];
`endif
                        state_reg <= BUSY;
                        count_reg <= CW'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    count_reg <= count_reg - 1'b1;
                end
                DONE: begin
                    state_reg  <= IDLE;
                    resp_valid <= 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
                    err        <= 1'b0;
`endif
                end
                default: state_reg <= IDLE;
            endcase

            if (access) begin
                state_reg  <= DONE;
                resp_valid <= 1'b1;
                mask_reg   <= !acc_ok;
`ifdef DM_MISALIGN_TRAP_EN
                err        <= !acc_ok;
`endif
            end
        end
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the CPU's load/store port; the CPU's memory stage is the initiator.
- Accepts one request at a time, holds it for a programmable latency, then returns one response pulse.
- Drives the stall signal back to the CPU pipeline while a request is outstanding.
- Owns a byte-writable word RAM, so the CPU can be exercised with realistic multi-cycle memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 2.
- LATENCY, 2, number of rising edges from request accept to the response cycle; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance enable; low freezes the block.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, byte lanes aligned to the word.
- req_be  in  4  byte enables; bit i selects wdata[8i+7:8i].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  full word read at the request address.
- stall  out  1  CPU must hold its memory stage.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, err=0.
  - Any in-flight request is abandoned; a pending store is dropped.
  - RAM contents are NOT reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_ready = enable.
  - Accept when req_valid & req_ready: latch we, word index, wdata and be.
  - Next state is DONE if LATENCY==1, otherwise BUSY with counter = LATENCY-1.
- BUSY: req_ready=0; the counter decrements each enabled edge. On the edge where counter==1, go to DONE.
- Entering DONE (that same edge):
  - Store: write only the enabled byte lanes.
  - Load and store: sample the word into resp_rdata. A store returns the post-write word.
- DONE: resp_valid=1 for exactly one cycle, req_ready=0, next state IDLE.
- Latency: resp_valid is high in the cycle after LATENCY rising edges following accept. Back-to-back throughput is one request per LATENCY+1 cycles.
- stall (combinational) = (IDLE & req_valid) | BUSY. It is low in DONE, so the CPU advances in the response cycle.
- enable=0:
  - State, counter and RAM are frozen; no accept.
  - resp_valid holds its value.
  - stall still follows the rule above.
- Address: word index = req_addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so accesses wrap modulo the RAM size; addr[1:0] is ignored unless the optional feature is enabled.
- req_be=0000 on a store is a no-op write but still produces a response.
- Request inputs are don't-care while req_ready=0.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port err (1 bit).
  - Legal combinations of addr[1:0] and be:
    - 00: 1111, 0011, 0001
    - 01: 0010
    - 10: 1100, 0100
    - 11: 1000
  - An illegal combination suppresses the write, returns resp_rdata=0, and pulses err=1 together with resp_valid.
- Undefined: no err port; every access is performed as given, and addr[1:0] is ignored.

Decomposition:
- Package dm_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - the legal-BE constant table;
  - the function is_aligned(addr[1:0], be);
  - the word-index width function clog2(DEPTH_WORDS).
- One natural sub-module: dm_byte_ram, a synchronous byte-enable RAM with write-then-read on the same port and same edge.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 1111, then load addr 0x10 -> each resp_valid arrives 2 edges after accept; load returns 0xDEADBEEF; stall high for 2 cycles per request.
- Partial store be=0100, wdata 0x00AB0000 to addr 0x10 (holding 0xDEADBEEF) -> load returns 0xDEABBEEF.
- DEPTH_WORDS=256: store 0x12345678 to addr 0x400 -> load from addr 0x000 returns 0x12345678 (wrap).
- Reset pulled low while in BUSY on a store of 0xFFFFFFFF to addr 0x20 -> resp_valid never fires; a later load of 0x20 returns the old value; req_ready=1 after reset is released.
- enable held low for 3 cycles mid-BUSY -> response delayed by exactly 3 cycles; data unchanged.
- With DM_MISALIGN_TRAP_EN: store be=1111 to addr 0x12 -> err=1 with resp_valid, resp_rdata=0, memory unchanged.
